// File: rtl/vga_frame_capture.sv
// Captures one WIDTH x HEIGHT window of an incoming VGA stream as RGB332 bytes
// and streams it to a frame-buffer write port, one pixel per cycle.
module vga_frame_capture #(
    parameter int unsigned WIDTH   = 200,
    parameter int unsigned HEIGHT  = 200,
    parameter int unsigned X_START = 350,
    parameter int unsigned Y_START = 150
) (
    input  logic        clk_25M,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [7:0]  data_r,
    input  logic [7:0]  data_g,
    input  logic [7:0]  data_b,
    input  logic        arm,
    input  logic        abort,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        frame_done,
    output logic        err_short
);

    // state   | meaning
    // IDLE    | waiting for arm
    // ARMED   | waiting for the next frame start (vsync falling edge)
    // CAPTURE | writing window pixels of the current frame
    // DONE    | last pixel written; frame_done pulse, back to IDLE
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int unsigned NPIX     = WIDTH * HEIGHT;
    localparam logic [15:0] LAST_IDX = 16'(NPIX - 1);
    localparam logic [10:0] X_LO     = 11'(X_START);
    localparam logic [10:0] X_HI     = 11'(X_START + WIDTH);
    localparam logic [10:0] Y_LO     = 11'(Y_START);
    localparam logic [10:0] Y_HI     = 11'(Y_START + HEIGHT);

    logic [1:0]  state_q, state_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [9:0]  x_pos_q, x_pos_d;
    logic [9:0]  y_pos_q, y_pos_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic        frame_done_q, frame_done_d;
    logic        err_short_q, err_short_d;

    logic        hs_fall;
    logic        vs_fall;
    logic        in_win;
    logic [7:0]  pix;
    logic        unused_bits;

    assign hs_fall = hs_q & ~hsync_in;
    assign vs_fall = vs_q & ~vsync_in;

    assign in_win = ({1'b0, x_pos_q} >= X_LO) && ({1'b0, x_pos_q} < X_HI) &&
                    ({1'b0, y_pos_q} >= Y_LO) && ({1'b0, y_pos_q} < Y_HI);

    assign pix         = {data_r[7:5], data_g[7:5], data_b[7:6]};
    assign unused_bits = ^{data_r[4:0], data_g[4:0], data_b[5:0]};

    always_comb begin
        hs_d = hsync_in;
        vs_d = vsync_in;

        if (hs_fall)
            x_pos_d = 10'd0;
        else if (x_pos_q == 10'd1023)
            x_pos_d = x_pos_q;
        else
            x_pos_d = x_pos_q + 10'd1;

        if (vs_fall)
            y_pos_d = 10'd0;
        else if (hs_fall && (y_pos_q != 10'd1023))
            y_pos_d = y_pos_q + 10'd1;
        else
            y_pos_d = y_pos_q;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        frame_done_d = 1'b0;
        err_short_d  = err_short_q;

        case (state_q)
            S_IDLE: begin
                if (arm && !abort) begin
                    state_d     = S_ARMED;
                    err_short_d = 1'b0;
                end
            end
            S_ARMED: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (vs_fall) begin
                    state_d   = S_CAPTURE;
                    idx_d     = 16'd0;
                    wr_addr_d = 16'd0;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (vs_fall) begin
                    // a new frame began before the window filled
                    state_d     = S_IDLE;
                    err_short_d = 1'b1;
                end else if (in_win) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = pix;
                    idx_d     = idx_q + 16'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            x_pos_q      <= 10'd0;
            y_pos_q      <= 10'd0;
            idx_q        <= 16'd0;
            wr_addr_q    <= 16'd0;
            wr_data_q    <= 8'd0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            x_pos_q      <= x_pos_d;
            y_pos_q      <= y_pos_d;
            idx_q        <= idx_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            frame_done_q <= frame_done_d;
            err_short_q  <= err_short_d;
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign frame_done = frame_done_q;
    assign err_short  = err_short_q;
    assign busy       = (state_q == S_ARMED) || (state_q == S_CAPTURE);

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a scaled-down raster: synthetic sync/pixel
// stream, expected writes derived from raster coordinates of each driven pixel.
module tb_vga_frame_capture;

    localparam int W    = 20;
    localparam int H    = 12;
    localparam int XS   = 30;
    localparam int YS   = 10;
    localparam int LINE = 64;
    localparam int NL   = 40;
    localparam int NPIX = W * H;

    logic        clk_25M;
    logic        rst;
    logic        hsync_in;
    logic        vsync_in;
    logic [7:0]  data_r;
    logic [7:0]  data_g;
    logic [7:0]  data_b;
    logic        arm;
    logic        abort;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        frame_done;
    logic        err_short;

    vga_frame_capture #(
        .WIDTH(W), .HEIGHT(H), .X_START(XS), .Y_START(YS)
    ) dut (
        .clk_25M   (clk_25M),
        .rst       (rst),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .data_r    (data_r),
        .data_g    (data_g),
        .data_b    (data_b),
        .arm       (arm),
        .abort     (abort),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .frame_done(frame_done),
        .err_short (err_short)
    );

    initial clk_25M = 1'b0;
    always #20 clk_25M = ~clk_25M;

    int n_tests = 0;
    int n_fail  = 0;

    // observed writes, appended by the monitor and never cleared
    logic [15:0] got_addr[$];
    logic [7:0]  got_data[$];
    int          wr_cnt   = 0;
    int          done_cnt = 0;

    // expected writes of the frame being captured
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    int          exp_idx;
    int          snap_cnt;

    always @(negedge clk_25M) begin
        if (wr_en) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            wr_cnt++;
        end
        if (frame_done) done_cnt++;
    end

    function automatic logic [7:0] pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r[7:5], g[7:5], b[7:6]};
    endfunction

    function automatic int first_diff(input int gb);
        for (int i = 0; i < exp_addr.size(); i++)
            if (got_addr[gb+i] !== exp_addr[i] || got_data[gb+i] !== exp_data[i]) return i;
        return -1;
    endfunction

    // One frame of NL lines, len clocks each. Pixel at raster (x,y) is the
    // sample presented while the receiver's position is (x,y): x counts clocks
    // since the hsync falling edge, so the first clock of a line still belongs
    // to the tail of the previous line.
    task automatic drive_frame(input int len, input bit cap, input int mode,
                               input int arm_line, input int abort_at, input int rst_at);
        int x, y, base, rs_hold;
        bit ab_fired, ab_check, rs_fired;
        logic [7:0] r, g, b, xb;
        base = wr_cnt; rs_hold = 0;
        ab_fired = 0; ab_check = 0; rs_fired = 0;
        for (int v = 0; v < NL; v++) begin
            for (int h = 0; h < len; h++) begin
                @(posedge clk_25M); #1;
                if (ab_check) begin
                    ab_check = 0;
                    n_tests++;
                    if (wr_en !== 1'b0 || busy !== 1'b0 || err_short !== 1'b0) begin
                        n_fail++;
                        $display("FAIL abort_next_cycle: wr_en=%b busy=%b err_short=%b, required 0 0 0",
                                 wr_en, busy, err_short);
                    end
                    snap_cnt = wr_cnt;
                end
                if (rs_hold > 0) begin
                    rs_hold--;
                    if (rs_hold == 0) rst = 1'b1;
                end
                hsync_in = (h < 8) ? 1'b0 : 1'b1;
                vsync_in = (v < 2) ? 1'b0 : 1'b1;
                x  = (h == 0) ? len - 1 : h - 1;
                y  = (h == 0) ? v - 1 : v;
                xb = x[7:0];
                case (mode)
                    0: begin r = xb; g = xb; b = xb; end
                    1: begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
                    2: begin r = 8'hE0; g = 8'h1C; b = 8'hC0; end
                    default: begin r = 8'hE0; g = 8'h00; b = 8'h00; end
                endcase
                data_r = r; data_g = g; data_b = b;
                arm   = (v == arm_line && h == 20);
                abort = 1'b0;
                if (abort_at > 0 && !ab_fired && wr_cnt - base >= abort_at) begin
                    abort = 1'b1; ab_fired = 1; ab_check = 1;
                end
                if (rst_at > 0 && !rs_fired && wr_cnt - base >= rst_at) begin
                    rs_fired = 1; rst = 1'b0; rs_hold = 3;
                    #1;
                    n_tests++;
                    if ({wr_en, busy, frame_done, err_short} !== 4'b0 || wr_addr !== 16'd0 || wr_data !== 8'd0) begin
                        n_fail++;
                        $display("FAIL rst_mid_capture: wr_en=%b busy=%b done=%b err=%b addr=%0d data=%h, required all 0",
                                 wr_en, busy, frame_done, err_short, wr_addr, wr_data);
                    end
                    snap_cnt = wr_cnt;
                end
                if (cap && y >= YS && y < YS + H && x >= XS && x < XS + W) begin
                    exp_addr.push_back(16'(exp_idx));
                    exp_data.push_back(pack(r, g, b));
                    exp_idx++;
                end
            end
        end
        @(posedge clk_25M); #1;
        arm = 1'b0; abort = 1'b0;
    endtask

    task automatic pulse_arm();
        @(posedge clk_25M); #1; arm = 1'b1;
        @(posedge clk_25M); #1; arm = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk_25M); #1; abort = 1'b1;
        @(posedge clk_25M); #1; abort = 1'b0;
    endtask

    task automatic new_frame_model();
        exp_addr.delete();
        exp_data.delete();
        exp_idx = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        data_r = 8'd0; data_g = 8'd0; data_b = 8'd0;
        arm = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk_25M);
        @(negedge clk_25M);
        n_tests++;
        if ({wr_en, busy, frame_done, err_short} !== 4'b0 || wr_addr !== 16'd0 || wr_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: wr_en=%b busy=%b done=%b err=%b addr=%0d data=%h, required all 0",
                     wr_en, busy, frame_done, err_short, wr_addr, wr_data);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk_25M);
    endtask

    task automatic test_ramp_frame();
        int gb, db, d;
        new_frame_model();
        gb = got_addr.size(); db = done_cnt;
        pulse_arm();
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ramp_armed_busy: got %b required 1", busy); end
        drive_frame(LINE, 1, 0, -1, 0, 0);
        n_tests++;
        if (got_addr.size() - gb != NPIX) begin
            n_fail++; $display("FAIL ramp_write_count: got %0d required %0d", got_addr.size() - gb, NPIX);
        end
        n_tests++;
        d = (got_addr.size() - gb == exp_addr.size()) ? first_diff(gb) : 0;
        if (d != -1) begin
            n_fail++;
            $display("FAIL ramp_contents: first difference at write %0d", d);
        end else begin
            n_tests++;
            if (got_addr[gb] !== 16'd0 || got_data[gb] !== pack(8'(XS), 8'(XS), 8'(XS))) begin
                n_fail++; $display("FAIL ramp_first_write: addr %0d data %h", got_addr[gb], got_data[gb]);
            end
            n_tests++;
            if (got_addr[gb+NPIX-1] !== 16'(NPIX - 1)) begin
                n_fail++; $display("FAIL ramp_last_addr: got %0d required %0d", got_addr[gb+NPIX-1], NPIX - 1);
            end
        end
        n_tests++;
        if (done_cnt - db != 1 || busy !== 1'b0 || err_short !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_done: frame_done pulses %0d busy=%b err=%b, required 1 0 0", done_cnt - db, busy, err_short);
        end
    endtask

    task automatic test_constant_color();
        int gb, bad;
        logic [7:0] want;
        for (int m = 2; m <= 3; m++) begin
            want = (m == 2) ? 8'hE3 : 8'hE0;
            gb = got_addr.size();
            new_frame_model();
            pulse_arm();
            drive_frame(LINE, 1, m, -1, 0, 0);
            bad = 0;
            for (int i = gb; i < got_data.size(); i++) if (got_data[i] !== want) bad++;
            n_tests++;
            if (got_addr.size() - gb != NPIX || bad != 0) begin
                n_fail++;
                $display("FAIL const_color_%h: writes %0d (required %0d), %0d bytes differ from %h",
                         want, got_addr.size() - gb, NPIX, bad, want);
            end
        end
    endtask

    task automatic test_arm_mid_frame();
        int gb, db, d;
        new_frame_model();
        gb = got_addr.size(); db = done_cnt;
        drive_frame(LINE, 0, 0, 15, 0, 0);
        n_tests++;
        if (got_addr.size() != gb || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arm_mid_frame_partial: writes %0d busy=%b, required 0 writes busy=1", got_addr.size() - gb, busy);
        end
        // following frame is random; the arm pulse inside it must be ignored
        drive_frame(LINE, 1, 1, 15, 0, 0);
        n_tests++;
        d = (got_addr.size() - gb == exp_addr.size()) ? first_diff(gb) : 0;
        if (exp_addr.size() != NPIX || d != -1) begin
            n_fail++;
            $display("FAIL arm_mid_frame_next: writes %0d required %0d, first difference %0d",
                     got_addr.size() - gb, NPIX, d);
        end
        n_tests++;
        if (done_cnt - db != 1) begin
            n_fail++; $display("FAIL arm_mid_frame_done: got %0d pulses required 1", done_cnt - db);
        end
    endtask

    task automatic test_short_lines();
        int gb, db, d, g2;
        new_frame_model();
        gb = got_addr.size(); db = done_cnt;
        pulse_arm();
        drive_frame(40, 1, 1, -1, 0, 0);
        n_tests++;
        d = (got_addr.size() - gb == exp_addr.size()) ? first_diff(gb) : 0;
        if (got_addr.size() - gb != H * (40 - XS) || d != -1) begin
            n_fail++;
            $display("FAIL short_lines_writes: got %0d required %0d, first difference %0d",
                     got_addr.size() - gb, H * (40 - XS), d);
        end
        n_tests++;
        if (err_short !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL short_lines_pending: err=%b busy=%b, required 0 1", err_short, busy);
        end
        g2 = got_addr.size();
        drive_frame(LINE, 0, 0, -1, 0, 0);
        n_tests++;
        if (err_short !== 1'b1 || busy !== 1'b0 || done_cnt != db || got_addr.size() != g2) begin
            n_fail++;
            $display("FAIL short_lines_err: err=%b busy=%b done=%0d extra_writes=%0d, required 1 0 0 0",
                     err_short, busy, done_cnt - db, got_addr.size() - g2);
        end
        pulse_arm();
        n_tests++;
        if (err_short !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL short_lines_rearm: err=%b busy=%b, required 0 1", err_short, busy);
        end
        pulse_abort();
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_armed: busy=%b required 0", busy); end
    endtask

    task automatic test_abort();
        int base, db;
        base = wr_cnt; db = done_cnt;
        pulse_arm();
        drive_frame(LINE, 0, 0, -1, 105, 0);
        n_tests++;
        if (wr_cnt - base != 106 || wr_cnt != snap_cnt) begin
            n_fail++;
            $display("FAIL abort_writes: total %0d (required 106), after abort %0d (required 0)",
                     wr_cnt - base, wr_cnt - snap_cnt);
        end
        n_tests++;
        if (done_cnt != db || err_short !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: done=%0d err=%b busy=%b, required 0 0 0", done_cnt - db, err_short, busy);
        end
    endtask

    task automatic test_reset_mid_capture();
        int gb, db, d;
        db = done_cnt;
        pulse_arm();
        drive_frame(LINE, 0, 0, -1, 0, 60);
        n_tests++;
        if (wr_cnt != snap_cnt || done_cnt != db || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: writes after reset %0d done=%0d busy=%b, required 0 0 0",
                     wr_cnt - snap_cnt, done_cnt - db, busy);
        end
        new_frame_model();
        gb = got_addr.size(); db = done_cnt;
        pulse_arm();
        drive_frame(LINE, 1, 1, -1, 0, 0);
        n_tests++;
        d = (got_addr.size() - gb == exp_addr.size()) ? first_diff(gb) : 0;
        if (exp_addr.size() != NPIX || d != -1 || done_cnt - db != 1) begin
            n_fail++;
            $display("FAIL rst_rearm_frame: writes %0d required %0d, first difference %0d, done %0d",
                     got_addr.size() - gb, NPIX, d, done_cnt - db);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_frame();
        test_constant_color();
        test_arm_mid_frame();
        test_short_lines();
        test_abort();
        test_reset_mid_capture();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
